// File: rtl/steer_dir_ctrl.sv
// Steering direction controller: turns a 5-element line-tracking sensor
// array into a 3-bit servo direction code (0..6, CENTER = straight ahead).
// The raw sensors are synchronised and debounced, and the debounced pattern
// is mapped to a target code. A small FSM handles enable, line loss and
// recovery. The output code slews one step per STEP_CYC cycles toward the
// target so the servo never jumps across its range.
module steer_dir_ctrl #(
    parameter int unsigned DEB_CYC  = 10000,
    parameter int unsigned STEP_CYC = 500000,
    parameter int unsigned LOST_CYC = 5000000,
    parameter logic [2:0]  CENTER   = 3'd3
) (
    input  logic       clk_10m,
    input  logic       rst,
    input  logic       en,
    input  logic [4:0] sens,
    output logic [2:0] dir,
    output logic       step_pulse,
    output logic       lost
);

    localparam int DW = (DEB_CYC  > 1) ? $clog2(DEB_CYC)  : 1;
    localparam int SW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam int LW = (LOST_CYC > 1) ? $clog2(LOST_CYC) : 1;

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYC - 1);
    localparam logic [LW-1:0] LOST_LAST = LW'(LOST_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2,
        LOST  = 2'd3
    } state_t;

    logic [4:0]    sync1_q;
    logic [4:0]    sync2_q;
    logic [4:0]    deb_q;
    logic [DW-1:0] deb_cnt_q [5];

    state_t        state_q;
    logic [2:0]    tgt_q;
    logic          lost_q;
    logic [LW-1:0] lost_cnt_q;

    logic [2:0]    dir_q;
    logic          step_q;
    logic [SW-1:0] step_cnt_q;

    logic          map_valid_d;
    logic [2:0]    map_code_d;

    // Two-flop synchroniser for the asynchronous sensor inputs.
    always_ff @(posedge clk_10m) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sens;
            sync2_q <= sync1_q;
        end
    end

    // Per-bit debounce: a new level is accepted only after DEB_CYC
    // consecutive cycles of disagreement with the current debounced level.
    always_ff @(posedge clk_10m) begin
        if (rst) begin
            deb_q <= '0;
            for (int i = 0; i < 5; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_q[i]     <= sync2_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounced pattern to target code; bit0 of the array steers toward 0.
    always_comb begin
        map_valid_d = 1'b1;
        map_code_d  = CENTER;
        case (deb_q)
            5'b00001, 5'b00011: map_code_d = 3'd0;
            5'b00111, 5'b00010: map_code_d = 3'd1;
            5'b00110:           map_code_d = 3'd2;
            5'b00100, 5'b01110: map_code_d = 3'd3;
            5'b01100:           map_code_d = 3'd4;
            5'b01000, 5'b11100: map_code_d = 3'd5;
            5'b11000, 5'b10000: map_code_d = 3'd6;
            default:            map_valid_d = 1'b0;
        endcase
    end

    // Tracking FSM: owns the slew target and the line-lost flag. A valid
    // pattern always wins over an expiring HOLD timer.
    always_ff @(posedge clk_10m) begin
        if (rst) begin
            state_q    <= IDLE;
            tgt_q      <= CENTER;
            lost_q     <= 1'b0;
            lost_cnt_q <= '0;
        end else if (!en) begin
            state_q    <= IDLE;
            tgt_q      <= CENTER;
            lost_q     <= 1'b0;
            lost_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= TRACK;
                    tgt_q   <= CENTER;
                    lost_q  <= 1'b0;
                end
                TRACK: begin
                    if (map_valid_d) begin
                        tgt_q <= map_code_d;
                    end else begin
                        state_q    <= HOLD;
                        lost_cnt_q <= '0;
                    end
                end
                HOLD: begin
                    if (map_valid_d) begin
                        state_q <= TRACK;
                        tgt_q   <= map_code_d;
                    end else if (lost_cnt_q == LOST_LAST) begin
                        state_q <= LOST;
                        tgt_q   <= CENTER;
                        lost_q  <= 1'b1;
                    end else begin
                        lost_cnt_q <= lost_cnt_q + 1'b1;
                    end
                end
                LOST: begin
                    if (map_valid_d) begin
                        state_q <= TRACK;
                        tgt_q   <= map_code_d;
                        lost_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Slew engine: one step toward the target every STEP_CYC cycles. The
    // timer keeps running across target changes and only clears on arrival.
    always_ff @(posedge clk_10m) begin
        if (rst) begin
            dir_q      <= CENTER;
            step_q     <= 1'b0;
            step_cnt_q <= '0;
        end else if (dir_q == tgt_q) begin
            step_q     <= 1'b0;
            step_cnt_q <= '0;
        end else if (step_cnt_q == STEP_LAST) begin
            step_q     <= 1'b1;
            step_cnt_q <= '0;
            if (tgt_q > dir_q) begin
                dir_q <= dir_q + 3'd1;
            end else begin
                dir_q <= dir_q - 3'd1;
            end
        end else begin
            step_q     <= 1'b0;
            step_cnt_q <= step_cnt_q + 1'b1;
        end
    end

    assign dir        = dir_q;
    assign step_pulse = step_q;
    assign lost       = lost_q;

endmodule
